ssp_rx_engine: RTL and testbench

- Parametrised next-generation SSP receive engine: deserialises SSPRXD frames of DATA_WIDTH bits, framed by SSPFSSIN, and writes whole words into the receive FIFO.
- Unlike the previous receiver, all logic runs in the PCLK domain. SSPCLKIN, SSPFSSIN and SSPRXD are synchronised and SSPCLKIN edges are detected.
- Adds a one-word pending buffer for a full FIFO, overrun detection, bit-order selection, a receive enable and back-to-back frames.
- Sits between the SSP pins and the RX FIFO inside the SSP module.

---
 rtl/ssp_rx_pkg.sv | 14 +
 rtl/ssp_sync_edge.sv | 49 ++++
 rtl/ssp_rx_engine.sv | 190 +++++++++++++++++++
 tb/tb_ssp_rx_engine.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_rx_pkg.sv
// Shared types and limits for the SSP receive engine.
package ssp_rx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DATA_WIDTH_MIN  = 4;
    localparam int unsigned DATA_WIDTH_MAX  = 16;
    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned OVR_CNT_W       = 8;

endpackage

// File: rtl/ssp_sync_edge.sv
// Multi-flop synchroniser for one asynchronous bit, with an optional
// registered rising-edge pulse taken from the synchronised output.
module ssp_sync_edge
    import ssp_rx_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
        $error("ssp_sync_edge: SYNC_STAGES below minimum");
    end

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

    if (EDGE_EN) begin : g_edge
        logic prev_q;

        // One-cycle pulse on a 0->1 transition of the synchronised level
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                prev_q <= 1'b0;
                rise   <= 1'b0;
            end else begin
                prev_q <= q;
                rise   <= q & ~prev_q;
            end
        end
    end else begin : g_no_edge
        assign rise = 1'b0;
    end

endmodule

// File: rtl/ssp_rx_engine.sv
// SSP receive engine: oversamples SSPCLKIN/SSPFSSIN/SSPRXD in the PCLK domain,
// deserialises frames and writes whole words to the RX FIFO via a one-word
// pending buffer. Define SSP_RX_OVR_CNT_EN to add the rx_ovr_cnt counter port.
module ssp_rx_engine
    import ssp_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LSB_FIRST   = 0
) (
    input  logic                  PCLK,
    input  logic                  CLEAR,
    input  logic                  rx_en,
    input  logic                  SSPCLKIN,
    input  logic                  SSPFSSIN,
    input  logic                  SSPRXD,
    input  logic                  rx_fifo_full,
    input  logic                  ovr_clr,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_wr,
    output logic                  rx_busy,
    output logic                  rx_overrun,
    output logic                  rx_ovr_sticky
`ifdef SSP_RX_OVR_CNT_EN
    ,
    output logic [OVR_CNT_W-1:0]  rx_ovr_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX) begin : g_bad_width
        $error("ssp_rx_engine: DATA_WIDTH out of range");
    end

    logic srise;
    logic fss_s;
    logic rxd_s;
    logic unused_sclk_q;
    logic unused_fss_rise;
    logic unused_rxd_rise;

    ssp_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sclk_sync (
        .clk  (PCLK),
        .rst  (CLEAR),
        .d    (SSPCLKIN),
        .q    (unused_sclk_q),
        .rise (srise)
    );

    ssp_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_fss_sync (
        .clk  (PCLK),
        .rst  (CLEAR),
        .d    (SSPFSSIN),
        .q    (fss_s),
        .rise (unused_fss_rise)
    );

    ssp_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_rxd_sync (
        .clk  (PCLK),
        .rst  (CLEAR),
        .d    (SSPRXD),
        .q    (rxd_s),
        .rise (unused_rxd_rise)
    );

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  pend_q, pend_d;
    logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [DATA_WIDTH-1:0] rx_data_d;
    logic                  rx_wr_d;
    logic                  rx_busy_d;
    logic                  rx_overrun_d;
    logic                  rx_ovr_sticky_d;
    logic                  word_done;
    logic                  drain;
    logic [DATA_WIDTH-1:0] shift_in;

    assign shift_in = (LSB_FIRST != 0) ? {rxd_s, shreg_q[DATA_WIDTH-1:1]}
                                       : {shreg_q[DATA_WIDTH-2:0], rxd_s};

    // Framing FSM, pending-buffer delivery and overrun flags
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shreg_d         = shreg_q;
        pend_d          = pend_q;
        pend_data_d     = pend_data_q;
        rx_data_d       = rx_data;
        rx_wr_d         = 1'b0;
        rx_overrun_d    = 1'b0;
        word_done       = 1'b0;
        drain           = pend_q & ~rx_fifo_full;

        case (state_q)
            IDLE: begin
                if (srise && fss_s && rx_en) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (srise) begin
                    if (!rx_en) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        shreg_d = shift_in;
                        if (bit_cnt_q == LAST_BIT) begin
                            word_done = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = fss_s ? SHIFT : IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (drain) begin
            rx_wr_d   = 1'b1;
            rx_data_d = pend_data_q;
            pend_d    = 1'b0;
        end

        // A draining pending slot frees room for the new word in the same cycle
        if (word_done) begin
            if (drain) begin
                pend_d      = 1'b1;
                pend_data_d = shift_in;
            end else if (pend_q) begin
                rx_overrun_d = 1'b1;
            end else if (rx_fifo_full) begin
                pend_d      = 1'b1;
                pend_data_d = shift_in;
            end else begin
                rx_wr_d   = 1'b1;
                rx_data_d = shift_in;
            end
        end

        rx_ovr_sticky_d = (rx_ovr_sticky & ~ovr_clr) | rx_overrun_d;
        rx_busy_d       = (state_d == SHIFT);
    end

    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shreg_q       <= '0;
            pend_q        <= 1'b0;
            pend_data_q   <= '0;
            rx_data       <= '0;
            rx_wr         <= 1'b0;
            rx_busy       <= 1'b0;
            rx_overrun    <= 1'b0;
            rx_ovr_sticky <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shreg_q       <= shreg_d;
            pend_q        <= pend_d;
            pend_data_q   <= pend_data_d;
            rx_data       <= rx_data_d;
            rx_wr         <= rx_wr_d;
            rx_busy       <= rx_busy_d;
            rx_overrun    <= rx_overrun_d;
            rx_ovr_sticky <= rx_ovr_sticky_d;
        end
    end

`ifdef SSP_RX_OVR_CNT_EN
    // Saturating overrun counter; clear beats a coincident increment
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            rx_ovr_cnt <= '0;
        end else if (ovr_clr) begin
            rx_ovr_cnt <= '0;
        end else if (rx_overrun_d && (rx_ovr_cnt != '1)) begin
            rx_ovr_cnt <= rx_ovr_cnt + OVR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ssp_rx_engine.sv
// Directed bench for ssp_rx_engine: table of single frames plus hand-written
// sequences for LSB-first, back-to-back, FIFO-full, overrun and abort cases.
module tb_ssp_rx_engine;

    logic        PCLK = 1'b0;
    logic        CLEAR;
    logic        rx_en, rx_en12;
    logic        SSPCLKIN, SSPFSSIN, SSPRXD;
    logic        rx_fifo_full, rx_fifo_full12;
    logic        ovr_clr, ovr_clr12;

    logic [7:0]  rx_data;
    logic        rx_wr, rx_busy, rx_overrun, rx_ovr_sticky;
    logic [11:0] rx_data12;
    logic        rx_wr12, rx_busy12, rx_overrun12, rx_ovr_sticky12;
`ifdef SSP_RX_OVR_CNT_EN
    logic [7:0]  rx_ovr_cnt, rx_ovr_cnt12;
`endif

    always #5 PCLK = ~PCLK;

    ssp_rx_engine dut (
        .PCLK          (PCLK),
        .CLEAR         (CLEAR),
        .rx_en         (rx_en),
        .SSPCLKIN      (SSPCLKIN),
        .SSPFSSIN      (SSPFSSIN),
        .SSPRXD        (SSPRXD),
        .rx_fifo_full  (rx_fifo_full),
        .ovr_clr       (ovr_clr),
        .rx_data       (rx_data),
        .rx_wr         (rx_wr),
        .rx_busy       (rx_busy),
        .rx_overrun    (rx_overrun),
        .rx_ovr_sticky (rx_ovr_sticky)
`ifdef SSP_RX_OVR_CNT_EN
        ,
        .rx_ovr_cnt    (rx_ovr_cnt)
`endif
    );

    ssp_rx_engine #(.DATA_WIDTH(12), .SYNC_STAGES(3), .LSB_FIRST(1)) dut12 (
        .PCLK          (PCLK),
        .CLEAR         (CLEAR),
        .rx_en         (rx_en12),
        .SSPCLKIN      (SSPCLKIN),
        .SSPFSSIN      (SSPFSSIN),
        .SSPRXD        (SSPRXD),
        .rx_fifo_full  (rx_fifo_full12),
        .ovr_clr       (ovr_clr12),
        .rx_data       (rx_data12),
        .rx_wr         (rx_wr12),
        .rx_busy       (rx_busy12),
        .rx_overrun    (rx_overrun12),
        .rx_ovr_sticky (rx_ovr_sticky12)
`ifdef SSP_RX_OVR_CNT_EN
        ,
        .rx_ovr_cnt    (rx_ovr_cnt12)
`endif
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int wr_cnt = 0, wr_cnt12 = 0, ovr_cyc = 0, full_viol = 0;
    int last_wr_cyc = 0, last_wr_cyc12 = 0;
    logic [7:0]  wr_q[$];
    logic [11:0] last_data12 = '0;

    always @(posedge PCLK) cyc <= cyc + 1;

    // Record every FIFO write and overrun cycle away from the active edge
    always @(negedge PCLK) begin
        if (rx_wr) begin
            wr_cnt++;
            wr_q.push_back(rx_data);
            last_wr_cyc = cyc;
            if (rx_fifo_full) full_viol++;
        end
        if (rx_overrun) ovr_cyc++;
        if (rx_wr12) begin
            wr_cnt12++;
            last_data12 = rx_data12;
            last_wr_cyc12 = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge PCLK);
        #2;
    endtask

    task automatic tick(input logic fss, input logic rxd);
        @(posedge PCLK); #2;
        SSPFSSIN = fss;
        SSPRXD   = rxd;
        repeat (3) @(posedge PCLK);
        #2;
        SSPCLKIN = 1'b1;
        rise_cyc = cyc;
        repeat (4) @(posedge PCLK);
        #2;
        SSPCLKIN = 1'b0;
    endtask

    task automatic send_fss();
        tick(1'b1, 1'b0);
    endtask

    task automatic send_bits(input logic [15:0] word, input int w, input bit lsb, input bit fss_last);
        for (int i = 0; i < w; i++) begin
            tick(((i == w - 1) && fss_last) ? 1'b1 : 1'b0, lsb ? word[i] : word[w-1-i]);
        end
        SSPFSSIN = 1'b0;
    endtask

    function automatic logic [7:0] q_at(input int idx);
        return (wr_q.size() > idx) ? wr_q[idx] : 8'hxx;
    endfunction

    typedef struct {
        logic [7:0] word;
        logic       en;
        int         exp_wr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int w0, o0, rel_cyc;

        vecs[0] = '{word: 8'hA5, en: 1'b1, exp_wr: 1, exp_data: 8'hA5};
        vecs[1] = '{word: 8'h00, en: 1'b1, exp_wr: 1, exp_data: 8'h00};
        vecs[2] = '{word: 8'hFF, en: 1'b1, exp_wr: 1, exp_data: 8'hFF};
        vecs[3] = '{word: 8'h5A, en: 1'b0, exp_wr: 0, exp_data: 8'h00};
        vecs[4] = '{word: 8'h3C, en: 1'b1, exp_wr: 1, exp_data: 8'h3C};

        CLEAR = 1'b1; rx_en = 1'b1; rx_en12 = 1'b0;
        SSPCLKIN = 1'b0; SSPFSSIN = 1'b0; SSPRXD = 1'b0;
        rx_fifo_full = 1'b0; rx_fifo_full12 = 1'b0;
        ovr_clr = 1'b0; ovr_clr12 = 1'b0;

        idle(3);
        chk("reset rx_data", 32'(rx_data), 32'h0);
        chk("reset rx_wr", 32'(rx_wr), 32'h0);
        chk("reset rx_busy", 32'(rx_busy), 32'h0);
        chk("reset rx_overrun", 32'(rx_overrun), 32'h0);
        chk("reset rx_ovr_sticky", 32'(rx_ovr_sticky), 32'h0);
        CLEAR = 1'b0;
        idle(3);

        for (int i = 0; i < 5; i++) begin
            rx_en = vecs[i].en;
            w0 = wr_cnt;
            wr_q.delete();
            send_fss();
            send_bits(16'(vecs[i].word), 8, 1'b0, 1'b0);
            idle(10);
            chk($sformatf("vec%0d wr count", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_wr));
            chk($sformatf("vec%0d busy after", i), 32'(rx_busy), 32'h0);
            if (vecs[i].exp_wr == 1) begin
                chk($sformatf("vec%0d data", i), 32'(q_at(0)), 32'(vecs[i].exp_data));
                chk($sformatf("vec%0d latency", i), 32'(last_wr_cyc - rise_cyc), 32'd4);
            end
        end
        rx_en = 1'b1;

        // 12-bit LSB-first instance, three sync stages
        rx_en = 1'b0; rx_en12 = 1'b1;
        w0 = wr_cnt12;
        send_fss();
        send_bits(16'h03C1, 12, 1'b1, 1'b0);
        idle(10);
        chk("lsb12 wr count", 32'(wr_cnt12 - w0), 32'd1);
        chk("lsb12 data", 32'(last_data12), 32'h3C1);
        chk("lsb12 latency", 32'(last_wr_cyc12 - rise_cyc), 32'd5);
        chk("lsb12 busy after", 32'(rx_busy12), 32'h0);
        rx_en12 = 1'b0; rx_en = 1'b1;

        // Back-to-back frames
        w0 = wr_cnt; wr_q.delete();
        send_fss();
        send_bits(16'h0081, 8, 1'b0, 1'b1);
        send_bits(16'h007E, 8, 1'b0, 1'b0);
        idle(10);
        chk("b2b wr count", 32'(wr_cnt - w0), 32'd2);
        chk("b2b first", 32'(q_at(0)), 32'h81);
        chk("b2b second", 32'(q_at(1)), 32'h7E);

        // FIFO full -> pending -> drain on release
        rx_fifo_full = 1'b1;
        w0 = wr_cnt; wr_q.delete();
        send_fss();
        send_bits(16'h0011, 8, 1'b0, 1'b0);
        idle(10);
        chk("pend no wr", 32'(wr_cnt - w0), 32'd0);
        rx_fifo_full = 1'b0;
        rel_cyc = cyc;
        idle(4);
        chk("pend drain count", 32'(wr_cnt - w0), 32'd1);
        chk("pend drain data", 32'(q_at(0)), 32'h11);
        chk("pend drain timing", 32'(last_wr_cyc - rel_cyc), 32'd1);

        // Overrun: second word dropped while first is pending
        rx_fifo_full = 1'b1;
        w0 = wr_cnt; o0 = ovr_cyc; wr_q.delete();
        send_fss();
        send_bits(16'h0022, 8, 1'b0, 1'b0);
        send_fss();
        send_bits(16'h0033, 8, 1'b0, 1'b0);
        idle(10);
        chk("ovr pulse cycles", 32'(ovr_cyc - o0), 32'd1);
        chk("ovr sticky set", 32'(rx_ovr_sticky), 32'h1);
        chk("ovr no wr while full", 32'(wr_cnt - w0), 32'd0);
`ifdef SSP_RX_OVR_CNT_EN
        chk("ovr cnt one", 32'(rx_ovr_cnt), 32'd1);
`endif
        rx_fifo_full = 1'b0;
        idle(6);
        chk("ovr drain count", 32'(wr_cnt - w0), 32'd1);
        chk("ovr drain data", 32'(q_at(0)), 32'h22);
        chk("ovr sticky holds", 32'(rx_ovr_sticky), 32'h1);
        ovr_clr = 1'b1;
        idle(1);
        ovr_clr = 1'b0;
        idle(1);
        chk("ovr sticky cleared", 32'(rx_ovr_sticky), 32'h0);
`ifdef SSP_RX_OVR_CNT_EN
        chk("ovr cnt cleared", 32'(rx_ovr_cnt), 32'd0);
`endif

        // CLEAR mid-frame, then a clean frame
        send_fss();
        send_bits(16'h000F, 4, 1'b0, 1'b0);
        chk("abort busy mid", 32'(rx_busy), 32'h1);
        CLEAR = 1'b1;
        idle(2);
        chk("abort rx_data", 32'(rx_data), 32'h0);
        chk("abort rx_wr", 32'(rx_wr), 32'h0);
        chk("abort rx_busy", 32'(rx_busy), 32'h0);
        chk("abort rx_overrun", 32'(rx_overrun), 32'h0);
        CLEAR = 1'b0;
        idle(3);
        w0 = wr_cnt; wr_q.delete();
        send_fss();
        send_bits(16'h00C3, 8, 1'b0, 1'b0);
        idle(10);
        chk("post-abort count", 32'(wr_cnt - w0), 32'd1);
        chk("post-abort data", 32'(q_at(0)), 32'hC3);

        // rx_en dropped mid-frame
        w0 = wr_cnt; wr_q.delete();
        send_fss();
        send_bits(16'h000A, 4, 1'b0, 1'b0);
        chk("en-drop busy mid", 32'(rx_busy), 32'h1);
        rx_en = 1'b0;
        send_bits(16'h0005, 4, 1'b0, 1'b0);
        idle(10);
        chk("en-drop no wr", 32'(wr_cnt - w0), 32'd0);
        chk("en-drop busy after", 32'(rx_busy), 32'h0);
        rx_en = 1'b1;
        send_fss();
        send_bits(16'h0096, 8, 1'b0, 1'b0);
        idle(10);
        chk("en-drop recover data", 32'(q_at(0)), 32'h96);

        chk("wr while full", 32'(full_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
